// File: rtl/ext_uart_serial_bridge.sv
// Pin-level 8N1 UART bridge for the core's uart-write / uart-read ports.
// The TX and RX paths are independent, and received bytes queue in a small FIFO.
module ext_uart_serial_bridge #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [8:0] ext_uart_write_arg,
    output logic       ext_uart_write_out,
    input  logic       ext_uart_read_arg,
    output logic [8:0] ext_uart_read_out,
    output logic       TX,
    input  logic       RX,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] BIT_HALF = TW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t         tx_state_r;
    logic [TW-1:0]     tx_timer_r;
    logic [2:0]        tx_idx_r;
    logic [7:0]        tx_shift_r;
    logic              tx_line_r;

    rx_state_t         rx_state_r;
    logic [TW-1:0]     rx_timer_r;
    logic [2:0]        rx_idx_r;
    logic [7:0]        rx_shift_r;
    logic              rx_meta_r;
    logic              rx_sync_r;
    logic              rx_prev_r;
    logic              rx_frame_err_r;
    logic              rx_overrun_r;

    logic [7:0]        fifo_mem_r [RX_FIFO_DEPTH];
    logic [PW-1:0]     fifo_wr_r;
    logic [PW-1:0]     fifo_rd_r;
    logic [CW-1:0]     fifo_count_r;

    logic              fifo_valid_s;
    logic              pop_s;
    logic              room_s;
    logic              stop_sample_s;
    logic              push_s;

    // Ready is a function of TX state only, held low for the whole reset.
    assign ext_uart_write_out = RST_N && (tx_state_r == TX_IDLE);
    assign TX                 = tx_line_r;
    assign rx_frame_err       = rx_frame_err_r;
    assign rx_overrun         = rx_overrun_r;

    // TX serialiser: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_r <= TX_IDLE;
            tx_timer_r <= TW'(0);
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_line_r <= 1'b1;
                    if (ext_uart_write_arg[8]) begin
                        tx_shift_r <= ext_uart_write_arg[7:0];
                        tx_line_r  <= 1'b0;
                        tx_timer_r <= BIT_LAST;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_timer_r == TW'(0)) begin
                        tx_line_r  <= tx_shift_r[0];
                        tx_idx_r   <= 3'd0;
                        tx_timer_r <= BIT_LAST;
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_timer_r <= tx_timer_r - TW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_timer_r == TW'(0)) begin
                        tx_timer_r <= BIT_LAST;
                        if (tx_idx_r == 3'd7) begin
                            tx_line_r  <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_line_r  <= tx_shift_r[1];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_idx_r   <= tx_idx_r + 3'd1;
                        end
                    end else begin
                        tx_timer_r <= tx_timer_r - TW'(1);
                    end
                end
                TX_STOP: begin
                    tx_line_r <= 1'b1;
                    if (tx_timer_r == TW'(0)) begin
                        tx_state_r <= TX_IDLE;
                    end else begin
                        tx_timer_r <= tx_timer_r - TW'(1);
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_line_r  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fifo_valid_s  = (fifo_count_r != CW'(0));
    assign pop_s         = fifo_valid_s && ext_uart_read_arg;
    assign room_s        = (fifo_count_r < CW'(RX_FIFO_DEPTH)) || pop_s;
    assign stop_sample_s = (rx_state_r == RX_STOP) && (rx_timer_r == TW'(0));
    assign push_s        = stop_sample_s && rx_sync_r && room_s;

    // RX deserialiser: half-bit delay to mid start bit, then full-bit steps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state_r     <= RX_IDLE;
            rx_timer_r     <= TW'(0);
            rx_idx_r       <= 3'd0;
            rx_shift_r     <= 8'h00;
            rx_frame_err_r <= 1'b0;
            rx_overrun_r   <= 1'b0;
        end else begin
            rx_frame_err_r <= stop_sample_s && !rx_sync_r;
            rx_overrun_r   <= stop_sample_s && rx_sync_r && !room_s;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_timer_r <= BIT_HALF;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_timer_r == TW'(0)) begin
                        rx_idx_r   <= 3'd0;
                        rx_timer_r <= BIT_LAST;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_timer_r <= rx_timer_r - TW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_timer_r == TW'(0)) begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_timer_r <= BIT_LAST;
                        if (rx_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 3'd1;
                        end
                    end else begin
                        rx_timer_r <= rx_timer_r - TW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_timer_r == TW'(0)) begin
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_timer_r <= rx_timer_r - TW'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_wr_r    <= PW'(0);
            fifo_rd_r    <= PW'(0);
            fifo_count_r <= CW'(0);
        end else begin
            if (push_s) begin
                fifo_wr_r <= fifo_wr_r + PW'(1);
            end
            if (pop_s) begin
                fifo_rd_r <= fifo_rd_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_mem_r[fifo_wr_r] <= rx_shift_r;
        end
    end

    // Head of FIFO, data forced to zero when empty so reset presents 9'b0.
    always_comb begin
        ext_uart_read_out = 9'h000;
        if (fifo_valid_s) begin
            ext_uart_read_out = {1'b1, fifo_mem_r[fifo_rd_r]};
        end else begin
            ext_uart_read_out = 9'h000;
        end
    end

endmodule

// File: tb/tb_ext_uart_serial_bridge.sv
// Directed bench for ext_uart_serial_bridge at CLKS_PER_BIT=8, RX_FIFO_DEPTH=4.
module tb_ext_uart_serial_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] wr_arg = 9'h000;
    logic       wr_rdy;
    logic       rd_arg = 1'b0;
    logic [8:0] rd_out;
    logic       tx;
    logic       rx = 1'b1;
    logic       ferr;
    logic       ovr;

    int total = 0;
    int bad   = 0;

    ext_uart_serial_bridge #(.CLKS_PER_BIT(8), .RX_FIFO_DEPTH(4)) dut (
        .CLK                (clk),
        .RST_N              (rst_n),
        .ext_uart_write_arg (wr_arg),
        .ext_uart_write_out (wr_rdy),
        .ext_uart_read_arg  (rd_arg),
        .ext_uart_read_out  (rd_out),
        .TX                 (tx),
        .RX                 (rx),
        .rx_frame_err       (ferr),
        .rx_overrun         (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one RX frame starting at a negedge; optionally pops in the stop-sample cycle.
    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic pop_last);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int c = 0; c < 80; c++) begin
            rx = f[c / 8];
            if (pop_last && c == 79) rd_arg = 1'b1;
            @(negedge clk);
        end
        rx = 1'b1;
        rd_arg = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, rd_out, {1'b1, exp});
        rd_arg = 1'b1;
        @(negedge clk);
        rd_arg = 1'b0;
    endtask

    initial begin
        logic [9:0] frame;
        logic [9:0] rframe;
        int         low;
        logic       seen;

        // Reset state
        #12;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", wr_rdy, 1'b0);
        check("rst_read_out", rd_out, 9'h000);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", wr_rdy, 1'b1);
        @(negedge clk);

        // 1. TX 0xA5, then 0x3C held valid
        frame = 10'b1101001010;
        wr_arg = {1'b1, 8'hA5};
        @(negedge clk);
        wr_arg = {1'b1, 8'h3C};
        low = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 8 == 4 && i < 80) check($sformatf("tx_a5_bit%0d", i / 8), tx, frame[i / 8]);
            if (!wr_rdy) low++;
            else break;
            @(negedge clk);
        end
        check("ready_low_cycles", low, 80);
        check("stop_before_2nd", tx, 1'b1);
        @(negedge clk);
        check("2nd_accept_ready", wr_rdy, 1'b0);
        check("2nd_start_no_gap", tx, 1'b0);
        wr_arg = 9'h000;
        for (int i = 0; i < 200 && !wr_rdy; i++) @(negedge clk);
        check("2nd_done_ready", wr_rdy, 1'b1);
        check("2nd_done_tx", tx, 1'b1);

        // 2. RX 0x5A
        rx_frame(8'h5A, 1'b1, 1'b0);
        check("rx_5a", rd_out, 9'h15A);
        rd_arg = 1'b1;
        @(negedge clk);
        rd_arg = 1'b0;
        check("rx_5a_popped", rd_out[8], 1'b0);

        // 3. Overrun on 5th frame, then 5th frame kept with pop in stop-sample cycle
        for (int k = 1; k <= 5; k++) begin
            rx_frame(8'(k), 1'b1, 1'b0);
            check($sformatf("ovr_frame%0d", k), ovr, (k == 5));
        end
        pop_check("drain_01", 8'h01);
        pop_check("drain_02", 8'h02);
        pop_check("drain_03", 8'h03);
        pop_check("drain_04", 8'h04);
        check("drain_empty", rd_out[8], 1'b0);
        for (int k = 1; k <= 4; k++) rx_frame(8'(k), 1'b1, 1'b0);
        rx_frame(8'h05, 1'b1, 1'b1);
        check("ovr_with_pop", ovr, 1'b0);
        pop_check("keep_02", 8'h02);
        pop_check("keep_03", 8'h03);
        pop_check("keep_04", 8'h04);
        pop_check("keep_05", 8'h05);
        check("keep_empty", rd_out[8], 1'b0);

        // 4. Glitch and frame error
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (ferr || ovr || rd_out[8]) seen = 1'b1;
            @(negedge clk);
        end
        check("glitch_quiet", seen, 1'b0);
        rx_frame(8'h77, 1'b0, 1'b0);
        check("ferr_pulse", ferr, 1'b1);
        check("ferr_no_push", rd_out[8], 1'b0);
        @(negedge clk);
        check("ferr_one_cycle", ferr, 1'b0);
        check("ferr_still_empty", rd_out, 9'h000);

        // 5. Reset mid TX bit 3 / RX bit 4 with two bytes queued
        rx_frame(8'h11, 1'b1, 1'b0);
        rx_frame(8'h22, 1'b1, 1'b0);
        rframe = {1'b1, 8'h96, 1'b0};
        for (int c = 0; c < 44; c++) begin
            rx = rframe[c / 8];
            if (c == 8) wr_arg = {1'b1, 8'hA5};
            if (c == 9) wr_arg = 9'h000;
            @(negedge clk);
        end
        check("pre_rst_tx_bit3", tx, 1'b0);
        check("pre_rst_queued", rd_out, 9'h111);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_valid", rd_out[8], 1'b0);
        check("mid_rst_ready", wr_rdy, 1'b0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", wr_rdy, 1'b1);
        check("post_rst_empty", rd_out, 9'h000);
        repeat (100) @(negedge clk);
        check("post_rst_no_byte", rd_out[8], 1'b0);
        check("post_rst_no_ferr", ferr, 1'b0);

        // 6. Full duplex: TX 0xC3 while receiving 0x81
        frame  = 10'b1110000110;
        rframe = 10'b1100000010;
        for (int c = 0; c <= 81; c++) begin
            if (c % 8 == 5 && c < 80) check($sformatf("fd_tx_bit%0d", c / 8), tx, frame[c / 8]);
            if (c == 80) begin
                check("fd_rx_81", rd_out, 9'h181);
                check("fd_ready_low", wr_rdy, 1'b0);
            end
            if (c == 81) check("fd_ready_back", wr_rdy, 1'b1);
            rx = (c < 80) ? rframe[c / 8] : 1'b1;
            if (c == 0) wr_arg = {1'b1, 8'hC3};
            if (c == 1) wr_arg = 9'h000;
            @(negedge clk);
        end
        check("fd_no_ferr", ferr, 1'b0);
        check("fd_no_ovr", ovr, 1'b0);
        pop_check("fd_pop_81", 8'h81);
        check("fd_empty", rd_out[8], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ext_uart_serial_bridge.md
Name: ext_uart_serial_bridge

Overview:
- Responder end of the core's external UART interface. Accepts bytes offered on the core's uart-write port and serialises them onto a TX pin as 8N1.
- Deserialises 8N1 frames from an RX pin into a small FIFO that the core drains through its uart-read port.
- Pin-level alternative to the USB serial bridge on boards with a plain serial line; instantiated in the FPGA top next to the rv32 core.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per serial bit. Must be >= 4. Default gives 115200 baud at 12 MHz.
- RX_FIFO_DEPTH, 4, RX byte FIFO entries. Must be a power of two, >= 2.

Ports:
- CLK  input  1  sole clock.
- RST_N  input  1  asynchronous, active-low reset.
- ext_uart_write_arg  input  9  {valid, data[7:0]}: byte offered by the core.
- ext_uart_write_out  output  1  ready: bridge accepts the offered byte this cycle.
- ext_uart_read_arg  input  1  ready: core consumes the presented byte this cycle.
- ext_uart_read_out  output  9  {valid, data[7:0]}: head of the RX FIFO.
- TX  output  1  serial line out, idle high.
- RX  input  1  serial line in, asynchronous to CLK.
- rx_frame_err  output  1  one-cycle pulse when a frame is discarded for a bad stop bit.
- rx_overrun  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Behaviour:
Reset (RST_N low, asynchronous):
- TX=1; ext_uart_write_out=0 while in reset; ext_uart_read_out=9'b0.
- Pulses 0; RX synchroniser flops=1; FIFO empty; both FSMs in IDLE.
- Reset asserted mid-frame aborts immediately: TX goes high in the same instant, no partial byte reaches the FIFO.

Handshakes:
- A transfer occurs only in a cycle where valid and ready are both high at the CLK edge.
- ext_uart_write_out and ext_uart_read_out are registered-state functions only. They are never combinational on the *_arg inputs.

TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
- IDLE: ready=1, TX=1. On accept at edge N, latch data and enter START; ready=0 from N+1.
- START: TX=0 for CLKS_PER_BIT cycles.
- DATA: bits 0..7, LSB first, each held CLKS_PER_BIT cycles. 3-bit index; leave after bit 7.
- STOP: TX=1 for CLKS_PER_BIT cycles, then IDLE.
- ready is low for exactly 10*CLKS_PER_BIT cycles per byte. Back-to-back bytes therefore have no extra idle gap.
- Bit timer counts CLKS_PER_BIT-1 down to 0, width $clog2(CLKS_PER_BIT).

RX path:
- RX passes through a 2-flop synchroniser before any use.

RX FSM, states IDLE -> START -> DATA -> STOP:
- IDLE: a falling edge of the synchronised RX (1 then 0) enters START with the timer at CLKS_PER_BIT/2 (integer division).
- START: at timer expiry, sample. If 1 (glitch), return to IDLE with no pulses. If 0, enter DATA.
- DATA: sample 8 bits at CLKS_PER_BIT intervals, mid-bit, LSB first, into a shift register.
- STOP: sample once after CLKS_PER_BIT cycles.
  - Sample 0: pulse rx_frame_err for 1 cycle, discard the byte, go to IDLE.
  - Sample 1: push the byte if there is room, else pulse rx_overrun and drop it.
  - Either way, go to IDLE right after the stop sample (mid-stop-bit), so an immediately following start edge is caught.

FIFO:
- Circular buffer with read/write pointers that wrap modulo RX_FIFO_DEPTH, plus an occupancy counter of width $clog2(RX_FIFO_DEPTH)+1.
- valid = (count != 0); data = entry at the read pointer. A pop happens on valid && ext_uart_read_arg.
- Room for a push means count < RX_FIFO_DEPTH, or a pop in the same cycle. A simultaneous push and pop when full succeeds, count unchanged.
- Simultaneous push and pop when empty: the pop does not occur (valid=0), the push lands, count becomes 1.
- Bytes are delivered in arrival order. A newly pushed byte is visible on ext_uart_read_out the cycle after the push.

Independence:
- TX and RX are fully independent; full-duplex operation is required.

Test Plan:
Bench runs with CLKS_PER_BIT=8, RX_FIFO_DEPTH=4.
1. Write 0xA5 from IDLE:
   - ready falls the next cycle.
   - TX shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit for 8 cycles.
   - ready stays low for exactly 80 cycles.
   - A second byte 0x3C held valid is accepted on the first ready cycle and starts with no idle gap.
2. Drive RX frame 0x5A with a good stop bit:
   - read_out = {1, 0x5A} the cycle after the stop sample.
   - Holding read_arg=1 for one cycle gives valid=0 afterwards.
3. Drive 5 frames 0x01..0x05 with read_arg=0:
   - The 5th frame pulses rx_overrun once.
   - Draining returns 0x01..0x04 in order, then valid=0.
   - Repeat with read_arg=1 asserted exactly in the 5th stop-sample cycle: no overrun, and 0x05 is kept.
4. Faults on RX:
   - A 3-cycle low glitch on idle RX produces no pulse and no byte.
   - A frame 0x77 with stop bit 0 pulses rx_frame_err once, and nothing is pushed.
5. Reset mid-operation: assert RST_N low during TX bit 3 and during RX bit 4 with 2 bytes already queued. Required immediately, without a CLK edge:
   - TX=1, read_out valid=0.
   - After release, ready=1 on the first cycle and the FIFO is empty.
6. Full duplex: send 0xC3 on TX while receiving 0x81 on RX, overlapping. Both complete bit-exact with no cross-interference.
